decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Instruction-decode stage directly downstream of fetch; consumes fetch's ir/npc.
//  Holds the 32x32 register file (write port driven by writeback).
//  Decodes immediates and destination register; computes branch target.
//  Detects load-use hazards and feeds a registered ID/EX bundle to execute.
// PARAMETERS
//  DATA_W   32  datapath / instruction width
//  RF_DEPTH 32  number of architectural registers
//  RF_AW    5   register address width (log2 RF_DEPTH)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  ir_i       in   DATA_W  instruction from fetch (fetch ir_o)
//  npc_i      in   DATA_W  next PC from fetch (fetch npc)
//  if_valid_i in   1       ir_i/npc_i valid this cycle
//  stall_i    in   1       downstream stall: hold ID/EX bundle
//  flush_i    in   1       branch taken: kill instruction in decode
//  wb_en_i    in   1       register-file write enable
//  wb_addr_i  in   RF_AW   write address
//  wb_data_i  in   DATA_W  write data
//  hazard_o   out  1       load-use hazard; fetch must hold PC/ir (comb.)
//  id_valid_o out  1       ID/EX bundle valid
//  npc_o      out  DATA_W  registered npc
//  rs_val_o   out  DATA_W  register[ir[25:21]]
//  rt_val_o   out  DATA_W  register[ir[20:16]]
//  imm_o      out  DATA_W  extended ir[15:0]
//  br_tgt_o   out  DATA_W  npc + (sign-ext imm << 2), mod 2^32
//  dst_o      out  RF_AW   destination register
//  opcode_o   out  6       ir[31:26]
//  funct_o    out  6       ir[5:0]
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs and ID/EX regs = 0; all RF entries = 0.
//  - Latency 1: decode of ir_i presented cycle N appears on outputs at edge N+1.
//  - RF: read combinational; write on clk edge when wb_en_i and wb_addr_i!=0.
//    r0 always reads 0. Same-cycle write+read of same addr -> wb_data_i bypassed.
//  - imm_o: zero-extend for opcode 0x0C/0x0D/0x0E (ANDI/ORI/XORI), else sign-extend.
//  - dst_o: opcode 0 -> ir[15:11]; opcode 0x03 (JAL) -> 31; else ir[20:16].
//  - Load-use: hazard_o=1 when id_valid_o && opcode_o==0x23 (LW) && dst_o!=0 &&
//    if_valid_i && (dst_o==ir_i[25:21] || dst_o==ir_i[20:16]).
//  - Per edge, priority: flush_i > stall_i > hazard_o > normal.
//    flush_i: id_valid_o<=0, bundle zeroed (bubble).
//    stall_i: all ID/EX regs hold (hazard_o still evaluated, no effect).
//    hazard_o: bubble inserted (id_valid_o<=0); ir_i re-presented next cycle by fetch.
//    normal: id_valid_o<=if_valid_i; bundle loads decode of ir_i.
//  - if_valid_i=0 in normal case: id_valid_o<=0, other fields don't-care (zeroed).
//  - RF writes proceed regardless of stall/flush/hazard.
//  - Reset asserted mid-stream: immediate clear, no partial state retained.
// TESTING
//  1 Reset: rst=0 -> all outputs 0; release, RF reads 0 for any addr.
//  2 Write r5=0x1234 via wb, then ir_i=0x00A53020 (add r6,r5,r5) -> next edge
//    rs_val_o=rt_val_o=0x1234, dst_o=6, opcode_o=0, funct_o=0x20, id_valid_o=1.
//  3 Bypass: wb r7=0xDEAD same cycle as ir_i reading r7 -> rs_val_o=0xDEAD; wb r0=5 -> r0 reads 0.
//  4 Imm: ir_i=0x3402FFFF (ORI) -> imm_o=0x0000FFFF; ir_i=0x2002FFFF (ADDI) -> imm_o=0xFFFFFFFF;
//    npc_i=0x8, BEQ imm=0xFFFF -> br_tgt_o=0x4.
//  5 Load-use: LW r8 then ADD reading r8 -> hazard_o=1, next id_valid_o=0; re-presented ADD decodes.
//  6 flush_i with stall_i both high -> id_valid_o=0; stall_i alone -> outputs unchanged.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage with 32x32 register file, immediate/branch decode, load-use detect and registered ID/EX bundle
// Ports: clk/rst (async, active-low) | ir_i, npc_i, if_valid_i from fetch | stall_i, flush_i pipeline control
//        wb_en_i/wb_addr_i/wb_data_i register-file write | hazard_o (comb) to fetch | ID/EX bundle outputs
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32,
  parameter int RF_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ir_i,
  input  logic [DATA_W-1:0] npc_i,
  input  logic              if_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [RF_AW-1:0]  wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              hazard_o,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] npc_o,
  output logic [DATA_W-1:0] rs_val_o,
  output logic [DATA_W-1:0] rt_val_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] br_tgt_o,
  output logic [RF_AW-1:0]  dst_o,
  output logic [5:0]        opcode_o,
  output logic [5:0]        funct_o
);
  localparam int BW = 5*DATA_W + RF_AW + 13;
  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [DATA_W-1:0] rf_d [RF_DEPTH];
  logic [BW-1:0]     id_q, id_d;
  logic [5:0]        op;
  logic [RF_AW-1:0]  dst;
  logic [DATA_W-1:0] imm, br;
  logic              unused;
  assign unused = ^ir_i[10:6];
  // rf_d holds the post-write image, so reading it gives the same-cycle bypass; r0 is never written
  always_comb begin
    rf_d = rf_q;
    if (wb_en_i && wb_addr_i != '0) rf_d[wb_addr_i] = wb_data_i;
  end
  always_comb begin
    op   = ir_i[31:26];
    imm  = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {{(DATA_W-16){1'b0}}, ir_i[15:0]}
                                                        : {{(DATA_W-16){ir_i[15]}}, ir_i[15:0]};
    br   = npc_i + {{(DATA_W-18){ir_i[15]}}, ir_i[15:0], 2'b00};
    dst  = op == 6'h00 ? ir_i[15:11] : op == 6'h03 ? '1 : ir_i[20:16];
    id_d = flush_i ? '0 : stall_i ? id_q : (hazard_o || !if_valid_i) ? '0
         : {1'b1, npc_i, rf_d[ir_i[25:21]], rf_d[ir_i[20:16]], imm, br, dst, op, ir_i[5:0]};
  end
  assign {id_valid_o, npc_o, rs_val_o, rt_val_o, imm_o, br_tgt_o, dst_o, opcode_o, funct_o} = id_q;
  assign hazard_o = id_valid_o && opcode_o == 6'h23 && dst_o != '0 && if_valid_i &&
                    (dst_o == ir_i[25:21] || dst_o == ir_i[20:16]);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      id_q <= '0;
    end else begin
      rf_q <= rf_d;
      id_q <= id_d;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven vectors and hand sequences checked through an expected-output queue
module tb_decode_stage;
  logic        clk = 0, rst = 0;
  logic [31:0] ir_i = 0, npc_i = 0, wb_data_i = 0;
  logic        if_valid_i = 0, stall_i = 0, flush_i = 0, wb_en_i = 0;
  logic [4:0]  wb_addr_i = 0;
  logic        hazard_o, id_valid_o;
  logic [31:0] npc_o, rs_val_o, rt_val_o, imm_o, br_tgt_o;
  logic [4:0]  dst_o;
  logic [5:0]  opcode_o, funct_o;

  decode_stage dut (
    .clk(clk), .rst(rst), .ir_i(ir_i), .npc_i(npc_i), .if_valid_i(if_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .hazard_o(hazard_o), .id_valid_o(id_valid_o), .npc_o(npc_o),
    .rs_val_o(rs_val_o), .rt_val_o(rt_val_o), .imm_o(imm_o), .br_tgt_o(br_tgt_o),
    .dst_o(dst_o), .opcode_o(opcode_o), .funct_o(funct_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] npc, rs, rt, imm, br; logic [4:0] dst; logic [5:0] op, fn;
  } out_t;
  typedef struct {
    logic [31:0] ir, npc; logic wb_en; logic [4:0] wa; logic [31:0] wd; out_t e;
  } vec_t;

  out_t sb[$];
  vec_t tbl[$];
  int   passed = 0, total = 0;

  function automatic out_t mk(logic v, logic [31:0] npc, rs, rt, imm, br,
                              logic [4:0] dst, logic [5:0] op, fn);
    out_t o;
    o.v = v; o.npc = npc; o.rs = rs; o.rt = rt; o.imm = imm; o.br = br;
    o.dst = dst; o.op = op; o.fn = fn;
    return o;
  endfunction

  function automatic vec_t mv(logic [31:0] ir, npc, logic en, logic [4:0] wa, logic [31:0] wd, out_t e);
    vec_t t;
    t.ir = ir; t.npc = npc; t.wb_en = en; t.wa = wa; t.wd = wd; t.e = e;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  task automatic pop_cmp(string tag);
    out_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, e.v});
    chk({tag, ".npc"}, npc_o, e.npc);
    chk({tag, ".rs_val"}, rs_val_o, e.rs);
    chk({tag, ".rt_val"}, rt_val_o, e.rt);
    chk({tag, ".imm"}, imm_o, e.imm);
    chk({tag, ".br_tgt"}, br_tgt_o, e.br);
    chk({tag, ".dst"}, {27'b0, dst_o}, {27'b0, e.dst});
    chk({tag, ".opcode"}, {26'b0, opcode_o}, {26'b0, e.op});
    chk({tag, ".funct"}, {26'b0, funct_o}, {26'b0, e.fn});
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic drive(logic [31:0] ir, npc, logic iv);
    ir_i = ir; npc_i = npc; if_valid_i = iv;
  endtask

  out_t z, hold;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(mv(32'h00A53020, 32'h100, 0, 0, 0, mk(1, 32'h100, 0, 0, 32'h3020, 32'hC180, 6, 0, 6'h20)));
    tbl.push_back(mv(32'h00000000, 32'h4, 1, 5, 32'h1234, mk(1, 32'h4, 0, 0, 0, 32'h4, 0, 0, 0)));
    tbl.push_back(mv(32'h00A53020, 32'h8, 0, 0, 0, mk(1, 32'h8, 32'h1234, 32'h1234, 32'h3020, 32'hC088, 6, 0, 6'h20)));
    tbl.push_back(mv(32'h00E00820, 32'h10, 1, 7, 32'hDEAD, mk(1, 32'h10, 32'hDEAD, 0, 32'h820, 32'h2090, 1, 0, 6'h20)));
    tbl.push_back(mv(32'h00071020, 32'h20, 1, 0, 32'h5, mk(1, 32'h20, 0, 32'hDEAD, 32'h1020, 32'h40A0, 2, 0, 6'h20)));
    tbl.push_back(mv(32'h00000000, 32'h0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mv(32'h3402FFFF, 32'h40, 0, 0, 0, mk(1, 32'h40, 0, 0, 32'h0000FFFF, 32'h3C, 2, 6'h0D, 6'h3F)));
    tbl.push_back(mv(32'h2002FFFF, 32'h44, 0, 0, 0, mk(1, 32'h44, 0, 0, 32'hFFFFFFFF, 32'h40, 2, 6'h08, 6'h3F)));
    tbl.push_back(mv(32'h10A7FFFF, 32'h8, 0, 0, 0, mk(1, 32'h8, 32'h1234, 32'hDEAD, 32'hFFFFFFFF, 32'h4, 7, 6'h04, 6'h3F)));
    tbl.push_back(mv(32'h0C000010, 32'h100, 0, 0, 0, mk(1, 32'h100, 0, 0, 32'h10, 32'h140, 31, 6'h03, 6'h10)));
    tbl.push_back(mv(32'h30008000, 32'h30000, 0, 0, 0, mk(1, 32'h30000, 0, 0, 32'h8000, 32'h10000, 0, 6'h0C, 0)));
    tbl.push_back(mv(32'h38008001, 32'h0, 0, 0, 0, mk(1, 0, 0, 0, 32'h8001, 32'hFFFE0004, 0, 6'h0E, 6'h01)));

    drive(32'h00A53020, 32'h100, 1);
    sb.push_back(z);
    step("reset");
    chk("reset.hazard", {31'b0, hazard_o}, 0);
    @(negedge clk) rst = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ir, tbl[i].npc, 1);
      wb_en_i = tbl[i].wb_en; wb_addr_i = tbl[i].wa; wb_data_i = tbl[i].wd;
      sb.push_back(tbl[i].e);
      step($sformatf("vec%0d", i));
    end
    wb_en_i = 0;

    drive(32'h8C080000, 32'h200, 1);
    #1 chk("lu.hazard_pre", {31'b0, hazard_o}, 0);
    sb.push_back(mk(1, 32'h200, 0, 0, 0, 32'h200, 8, 6'h23, 0));
    step("lu.lw");
    drive(32'h01004820, 32'h204, 1);
    #1 chk("lu.hazard_rs", {31'b0, hazard_o}, 1);
    sb.push_back(z);
    step("lu.bubble");
    chk("lu.hazard_clear", {31'b0, hazard_o}, 0);
    sb.push_back(mk(1, 32'h204, 0, 0, 32'h4820, 32'h12284, 9, 0, 6'h20));
    step("lu.replay");

    drive(32'h8C080000, 32'h208, 1);
    sb.push_back(mk(1, 32'h208, 0, 0, 0, 32'h208, 8, 6'h23, 0));
    step("lu.lw2");
    drive(32'h00084820, 32'h20C, 0);
    #1 chk("lu.hazard_novalid", {31'b0, hazard_o}, 0);
    sb.push_back(z);
    step("lu.invalid");
    drive(32'h8C080000, 32'h20C, 1);
    sb.push_back(mk(1, 32'h20C, 0, 0, 0, 32'h20C, 8, 6'h23, 0));
    step("lu.lw3");
    drive(32'h00084820, 32'h210, 1);
    #1 chk("lu.hazard_rt", {31'b0, hazard_o}, 1);
    sb.push_back(z);
    step("lu.bubble2");

    hold = mk(1, 32'h210, 0, 0, 32'h4820, 32'h12290, 9, 0, 6'h20);
    sb.push_back(hold);
    step("st.load");
    drive(32'h3402FFFF, 32'h300, 1);
    stall_i = 1;
    sb.push_back(hold);
    step("st.hold");
    flush_i = 1;
    sb.push_back(z);
    step("st.flush");
    stall_i = 0; flush_i = 0;

    drive(32'h10A7FFFF, 32'h8, 1);
    sb.push_back(mk(1, 32'h8, 32'h1234, 32'hDEAD, 32'hFFFFFFFF, 32'h4, 7, 6'h04, 6'h3F));
    step("rst.pre");
    rst = 0;
    #1 sb.push_back(z);
    pop_cmp("rst.async");
    @(negedge clk) rst = 1;
    sb.push_back(mk(1, 32'h8, 0, 0, 32'hFFFFFFFF, 32'h4, 7, 6'h04, 6'h3F));
    step("rst.rf_clear");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
